// File: rtl/ultrasonic_scan_scheduler_pkg.sv
// Shared types and constants for the ultrasonic scan scheduler.
package ultra_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StTrig,
        StWaitRise,
        StMeasure,
        StGuard
    } state_e;

    // Sliced down to DIST_W by the user; reported width on any timeout.
    localparam logic [31:0] WidthSentinel = '1;

    function automatic int unsigned id_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ultrasonic_scan_scheduler_echo_sync_edge.sv
// Two-flop synchronizer for one asynchronous echo pin, plus a delayed copy for
// single-cycle rise/fall pulses.
module echo_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/ultrasonic_scan_scheduler.sv
// Round-robin scheduler sharing one acoustic channel across several rangefinders:
// trigger, time the echo, report a tagged sample, then hold a guard gap.
module ultrasonic_scan_scheduler
    import ultra_pkg::*;
#(
    parameter int unsigned N_SENSORS      = 4,
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned GUARD_CYCLES   = 3000000,
    parameter int unsigned CNT_W          = 24,
    parameter int unsigned DIST_W         = 16,
    localparam int unsigned ID_W          = id_width(N_SENSORS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [N_SENSORS-1:0] sensor_mask,
    input  logic [N_SENSORS-1:0] echo,
    output logic [N_SENSORS-1:0] trigger,
    output logic                 meas_valid,
    output logic [ID_W-1:0]      meas_id,
    output logic [DIST_W-1:0]    meas_width,
    output logic                 meas_timeout,
    output logic                 busy
);

    localparam logic [CNT_W-1:0]  TrigLast    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TimeoutFull = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  GuardLast   = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [DIST_W-1:0] WidthMax    = WidthSentinel[DIST_W-1:0];

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIST_W-1:0]  width_q, width_d;
    logic [ID_W-1:0]    cur_id_q, cur_id_d;

    logic               meas_valid_q;
    logic [ID_W-1:0]    meas_id_q;
    logic [DIST_W-1:0]  meas_width_q;
    logic               meas_timeout_q;

    logic                 emit, emit_timeout;
    logic [DIST_W-1:0]    emit_width;
    logic [N_SENSORS-1:0] rise_vec, fall_vec;
    logic                 echo_rise, echo_fall;
    logic                 mask_any;
    logic [ID_W-1:0]      next_id, probe_id;
    logic                 found;
    int unsigned          probe;

    for (genvar g = 0; g < N_SENSORS; g++) begin : g_sync
        echo_sync_edge u_sync (
            .clk  (clk),
            .rst  (rst),
            .din  (echo[g]),
            .rise (rise_vec[g]),
            .fall (fall_vec[g])
        );
    end

    assign echo_rise = rise_vec[cur_id_q];
    assign echo_fall = fall_vec[cur_id_q];
    assign mask_any  = |sensor_mask;

    // Lowest enabled sensor strictly after cur_id, wrapping around.
    always_comb begin
        next_id  = cur_id_q;
        found    = 1'b0;
        probe    = 0;
        probe_id = '0;
        for (int unsigned i = 1; i <= N_SENSORS; i++) begin
            probe    = (32'(cur_id_q) + i) % N_SENSORS;
            probe_id = ID_W'(probe);
            if (!found && sensor_mask[probe_id]) begin
                found   = 1'b1;
                next_id = probe_id;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        width_d      = width_q;
        cur_id_d     = cur_id_q;
        emit         = 1'b0;
        emit_timeout = 1'b0;
        emit_width   = width_q;
        unique case (state_q)
            StIdle: begin
                if (enable && mask_any) begin
                    state_d  = StTrig;
                    cur_id_d = next_id;
                    cnt_d    = '0;
                end
            end
            StTrig: begin
                if (cnt_q == TrigLast) begin
                    state_d = StWaitRise;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWaitRise: begin
                // A rise on the final timeout cycle still starts a measurement.
                if (echo_rise) begin
                    state_d = StMeasure;
                    width_d = DIST_W'(1);
                    cnt_d   = CNT_W'(1);
                end else if (cnt_q == TimeoutLast) begin
                    emit         = 1'b1;
                    emit_timeout = 1'b1;
                    emit_width   = WidthMax;
                    state_d      = StGuard;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StMeasure: begin
                // cnt tracks elapsed echo time; width saturates independently.
                if (echo_fall) begin
                    emit    = 1'b1;
                    state_d = StGuard;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutFull) begin
                    emit         = 1'b1;
                    emit_timeout = 1'b1;
                    emit_width   = WidthMax;
                    state_d      = StGuard;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (width_q != WidthMax) width_d = width_q + DIST_W'(1);
                end
            end
            StGuard: begin
                if (cnt_q == GuardLast) begin
                    cnt_d = '0;
                    if (enable && mask_any) begin
                        state_d  = StTrig;
                        cur_id_d = next_id;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            width_q        <= '0;
            cur_id_q       <= ID_W'(N_SENSORS - 1);
            meas_valid_q   <= 1'b0;
            meas_id_q      <= '0;
            meas_width_q   <= '0;
            meas_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            width_q      <= width_d;
            cur_id_q     <= cur_id_d;
            meas_valid_q <= emit;
            if (emit) begin
                meas_id_q      <= cur_id_q;
                meas_width_q   <= emit_width;
                meas_timeout_q <= emit_timeout;
            end
        end
    end

    always_comb begin
        trigger = '0;
        if (state_q == StTrig) trigger[cur_id_q] = 1'b1;
    end

    assign busy         = (state_q != StIdle);
    assign meas_valid   = meas_valid_q;
    assign meas_id      = meas_id_q;
    assign meas_width   = meas_width_q;
    assign meas_timeout = meas_timeout_q;

endmodule

// File: tb/tb_ultrasonic_scan_scheduler.sv
// Randomized scoreboard bench: a sensor model answers each trigger with an echo and
// queues the sample it expects; a monitor pops and compares on every meas_valid.
module tb_ultrasonic_scan_scheduler;

    localparam int N    = 4;
    localparam int TRIG = 4;
    localparam int TMO  = 64;
    localparam int GRD  = 8;
    localparam int DW   = 8;
    localparam int WMAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [N-1:0]  sensor_mask;
    logic [N-1:0]  echo;
    logic [N-1:0]  trigger;
    logic          meas_valid;
    logic [1:0]    meas_id;
    logic [DW-1:0] meas_width;
    logic          meas_timeout;
    logic          busy;

    always #5 clk = ~clk;

    ultrasonic_scan_scheduler #(
        .N_SENSORS      (N),
        .TRIG_CYCLES    (TRIG),
        .TIMEOUT_CYCLES (TMO),
        .GUARD_CYCLES   (GRD),
        .CNT_W          (24),
        .DIST_W         (DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sensor_mask  (sensor_mask),
        .echo         (echo),
        .trigger      (trigger),
        .meas_valid   (meas_valid),
        .meas_id      (meas_id),
        .meas_width   (meas_width),
        .meas_timeout (meas_timeout),
        .busy         (busy)
    );

    typedef struct {
        int id;
        int width;
        int tmo;
        int lat;  // cycles from trigger fall to sample, -1 = unchecked
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_samples = 0;
    int   last_valid_cyc = 0;
    bit   valid_seen = 1'b0;
    bit   idle_seen = 1'b0;

    // Sensor environment configuration and per-sensor echo state.
    int   cfg_delay[N];
    int   cfg_dur[N];
    bit   cfg_rand[N];
    bit   cfg_pulse[N];
    int   cur_delay[N];
    int   cur_dur[N];
    int   t_echo[N];
    int   hi_cnt[N];
    int   fall_cyc[N];
    int   last_id;
    int   pick;
    bit   obs_now, obs_was;
    logic [N-1:0] prev_trig;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic bit bit_of(input logic [N-1:0] v, input int k);
        logic [N-1:0] s;
        s = v >> k;
        return s[0];
    endfunction

    function automatic logic [N-1:0] set_bit(input logic [N-1:0] v, input int k, input bit b);
        logic [N-1:0] one;
        one = 1;
        return b ? (v | (one << k)) : (v & ~(one << k));
    endfunction

    // Round-robin rule: first enabled sensor after the previous one, wrapping.
    function automatic int model_next(input logic [N-1:0] m, input int last);
        for (int i = 1; i <= N; i++) begin
            if (bit_of(m, (last + i) % N)) return (last + i) % N;
        end
        return -1;
    endfunction

    // Sample a sensor should produce for an echo lasting dur cycles (0 = no echo).
    function automatic exp_t expect_of(input int id, input int dur);
        exp_t e;
        e.id = id;
        if (dur == 0) begin
            e.width = WMAX; e.tmo = 1; e.lat = TMO;
        end else if (dur <= TMO) begin
            e.width = (dur > WMAX) ? WMAX : dur; e.tmo = 0; e.lat = -1;
        end else begin
            e.width = WMAX; e.tmo = 1; e.lat = -1;
        end
        return e;
    endfunction

    // Stimulus side: watch triggers, predict order and samples, drive echoes.
    always @(negedge clk) begin : obs
        if (rst) begin
            echo       = '0;
            prev_trig  = '0;
            last_id    = N - 1;
            valid_seen = 1'b0;
            idle_seen  = 1'b0;
            for (int k = 0; k < N; k++) t_echo[k] = -1;
        end else begin
            if (!busy) idle_seen = 1'b1;
            for (int k = 0; k < N; k++) begin
                obs_now = bit_of(trigger, k);
                obs_was = bit_of(prev_trig, k);
                if (obs_now && !obs_was) begin
                    check("trig_order", k, model_next(sensor_mask, last_id));
                    check("trig_onehot", $countones(trigger), 1);
                    if (valid_seen && !idle_seen) check("guard_gap", cyc - last_valid_cyc, GRD);
                    valid_seen = 1'b0;
                    idle_seen  = 1'b0;
                    last_id    = k;
                    hi_cnt[k]  = 1;
                    t_echo[k]  = -1;
                    if (cfg_rand[k]) begin
                        cur_delay[k] = $urandom_range(1, 20);
                        pick = $urandom_range(0, 9);
                        cur_dur[k] = (pick == 0) ? 0 : (pick == 1) ? TMO :
                                     (pick == 2) ? TMO + 1 : $urandom_range(1, TMO - 1);
                    end else begin
                        cur_delay[k] = cfg_delay[k];
                        cur_dur[k]   = cfg_dur[k];
                    end
                    sb.push_back(expect_of(k, cur_dur[k]));
                    if (cfg_pulse[k]) echo = set_bit(echo, k, 1'b1);
                end else if (obs_now) begin
                    hi_cnt[k]++;
                    echo = set_bit(echo, k, 1'b0);
                end else if (obs_was) begin
                    check("trig_width", hi_cnt[k], TRIG);
                    t_echo[k]   = 0;
                    fall_cyc[k] = cyc;
                end
                if (t_echo[k] >= 0) begin
                    echo = set_bit(echo, k, (cur_dur[k] > 0) && (t_echo[k] >= cur_delay[k]) &&
                                            (t_echo[k] < cur_delay[k] + cur_dur[k]));
                    t_echo[k]++;
                    if (t_echo[k] > cur_delay[k] + cur_dur[k]) t_echo[k] = -1;
                end
            end
            prev_trig = trigger;
        end
    end

    // Checking side: every strobe must match the oldest outstanding prediction.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && meas_valid) begin
            n_samples++;
            valid_seen     = 1'b1;
            last_valid_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_sample", 1, 0);
            end else begin
                e = sb.pop_front();
                check("meas_id", int'(meas_id), e.id);
                check("meas_width", int'(meas_width), e.width);
                check("meas_timeout", int'(meas_timeout), e.tmo);
                if (e.lat >= 0) check("timeout_latency", cyc - fall_cyc[e.id], e.lat);
            end
        end
    end

    task automatic wait_samples(input int target, input int budget);
        int k = 0;
        while (n_samples < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("sample_wait", int'(n_samples >= target), 1);
    endtask

    task automatic wait_trig(input int id, input bit level, input int budget);
        int k = 0;
        while (bit_of(trigger, id) != level && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("trigger_wait", int'(bit_of(trigger, id)), int'(level));
    endtask

    task automatic check_quiet_idle(input string name);
        int hits = 0;
        while (cyc < last_valid_cyc + GRD - 1) @(negedge clk);
        check({name, "_busy_guard"}, int'(busy), 1);
        @(negedge clk);
        check({name, "_busy_idle"}, int'(busy), 0);
        repeat (30) begin
            @(negedge clk);
            if (trigger != '0) hits++;
        end
        check({name, "_no_trigger"}, hits, 0);
        check({name, "_queue_empty"}, sb.size(), 0);
    endtask

    task automatic set_fixed(input int delay, input int dur);
        for (int k = 0; k < N; k++) begin
            cfg_delay[k] = delay;
            cfg_dur[k]   = dur;
            cfg_rand[k]  = 1'b0;
            cfg_pulse[k] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        sensor_mask = '0;
        set_fixed(5, 20);
        repeat (3) @(negedge clk);
        check("rst_trigger", int'(trigger), 0);
        check("rst_meas_valid", int'(meas_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_meas_fields", int'({meas_id, meas_width, meas_timeout}), 0);
        rst = 1'b0;

        // Empty mask keeps the block idle even when enabled.
        enable = 1'b1;
        repeat (10) @(negedge clk);
        check("mask0_idle", int'(busy), 0);

        // Full mask, 20-cycle echoes: 0,1,2,3,0.
        sensor_mask = 4'b1111;
        wait_samples(5, 1500);

        // Sensor 2 never answers.
        sensor_mask = 4'b0101;
        cfg_dur[2] = 0;
        wait_samples(n_samples + 3, 1000);

        // Fall exactly at the limit wins; longer echoes time out.
        sensor_mask = 4'b0011;
        cfg_dur[0] = TMO;
        cfg_dur[1] = 100;
        wait_samples(n_samples + 2, 1000);
        cfg_dur[0] = TMO + 1;
        wait_samples(n_samples + 2, 1000);

        // Random masks and echo lengths.
        for (int k = 0; k < N; k++) cfg_rand[k] = 1'b1;
        repeat (14) begin
            sensor_mask = 4'($urandom_range(1, 15));
            wait_samples(n_samples + 1, 400);
        end

        // enable dropped mid-measurement of sensor 1.
        set_fixed(3, 20);
        cfg_dur[1] = 40;
        sensor_mask = 4'b1111;
        wait_trig(1, 1'b1, 1500);
        wait_trig(1, 1'b0, 20);
        repeat (20) @(negedge clk);
        enable = 1'b0;
        wait_samples(n_samples + 1, 200);
        check_quiet_idle("enable_drop");

        // Reset during TRIG aborts; scan restarts at sensor 0.
        enable = 1'b1;
        wait_trig(2, 1'b1, 50);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("rst_mid_trigger", int'(trigger), 0);
        check("rst_mid_valid", int'(meas_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_samples(n_samples + 2, 500);

        // Echo pulse inside TRIG is ignored; mask cleared so the scan stops.
        sensor_mask = 4'b0100;
        cfg_dur[2] = 0;
        cfg_pulse[2] = 1'b1;
        wait_trig(2, 1'b1, 200);
        @(negedge clk);
        sensor_mask = '0;
        wait_samples(n_samples + 1, 200);
        check_quiet_idle("mask_clear");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, samples=%0d expected_all_done", n_samples);
        $fatal(1, "watchdog expired");
    end

endmodule
